// File: rtl/majority_counter.sv
// majority_counter: pipelined signed vote accumulator; ports clk, rst_n, store, core_result, flush -> sign_bit, zero_flag, acc_valid, busy (+ sat_flag with MAJORITY_COUNTER_SAT_EN, which saturates box instead of wrapping)
module majority_counter #(
  parameter int W       = 30,
  parameter int CORENUM = 16,
  parameter int GROUP   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [CORENUM-1:0] store,
  input  logic [CORENUM-1:0] core_result,
  input  logic               flush,
  output logic               sign_bit,
  output logic               zero_flag,
  output logic               acc_valid,
  output logic               busy
`ifdef MAJORITY_COUNTER_SAT_EN
  ,
  output logic               sat_flag
`endif
);
  localparam int NG = (CORENUM + GROUP - 1) / GROUP;
  localparam int PW = $clog2(GROUP + 1) + 1;
  localparam int SW = $clog2(CORENUM + 1) + 1;
  logic [2*CORENUM-1:0]    sel_q, sel_d;
  logic [2*NG*GROUP-1:0]   sel_pad;
  logic [NG-1:0][PW-1:0]   psum_q, psum_d;
  logic [W-1:0]            box_q, box_d, nxt;
  logic                    v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic signed [SW-1:0]    tot;
`ifdef MAJORITY_COUNTER_SAT_EN
  logic signed [W:0]       ext;
  logic                    ovf, sat_q, sat_d;
`endif
  always_comb begin
    sel_d = '0;
    for (int k = 0; k < CORENUM; k++)
      sel_d[2*k +: 2] = (flush || !store[k]) ? 2'b00 : core_result[k] ? 2'b01 : 2'b11;
    v1_d = !flush && |store;
  end
  always_comb begin
    sel_pad = (2*NG*GROUP)'(sel_q);
    psum_d  = '0;
    for (int g = 0; g < NG; g++)
      for (int j = 0; j < GROUP; j++)
        psum_d[g] = psum_d[g] + PW'($signed(sel_pad[2*(g*GROUP+j) +: 2]));
    if (flush) psum_d = '0;
    v2_d = !flush && v1_q;
  end
  always_comb begin
    tot = '0;
    for (int g = 0; g < NG; g++)
      tot = tot + SW'($signed(psum_q[g]));
`ifdef MAJORITY_COUNTER_SAT_EN
    // one guard bit: a mismatch between the top two bits means the true sum left the W-bit range
    ext   = (W+1)'($signed(box_q)) + (W+1)'(tot);
    ovf   = ext[W] ^ ext[W-1];
    nxt   = ovf ? {ext[W], {(W-1){~ext[W]}}} : ext[W-1:0];
    sat_d = flush ? 1'b0 : sat_q | (v2_q & ovf);
`else
    nxt = box_q + W'(tot);
`endif
    box_d = flush ? '0 : v2_q ? nxt : box_q;
    v3_d  = !flush && v2_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sel_q  <= '0;
      psum_q <= '0;
      box_q  <= '0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
`ifdef MAJORITY_COUNTER_SAT_EN
      sat_q  <= 1'b0;
`endif
    end else begin
      sel_q  <= sel_d;
      psum_q <= psum_d;
      box_q  <= box_d;
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      v3_q   <= v3_d;
`ifdef MAJORITY_COUNTER_SAT_EN
      sat_q  <= sat_d;
`endif
    end
  assign sign_bit  = box_q[W-1];
  assign zero_flag = box_q == '0;
  assign acc_valid = v3_q;
  assign busy      = v1_q | v2_q | v3_q;
`ifdef MAJORITY_COUNTER_SAT_EN
  assign sat_flag  = sat_q;
`endif
endmodule

// File: tb/tb_majority_counter.sv
// tb_majority_counter: scoreboard bench for majority_counter (default and W=6/CORENUM=5/GROUP=2 instances)
module tb_majority_counter;
  logic clk = 1'b0, rst_n = 1'b1, flush = 1'b0, fl1 = 1'b0;
  logic [15:0] store = '0, cr = '0;
  logic [4:0]  st1 = '0, cr1 = '0;
  logic sign0, zero0, acc0, busy0, sign1, zero1, acc1, busy1;
`ifdef MAJORITY_COUNTER_SAT_EN
  logic sat0, sat1;
`endif
  int nvec = 0, nerr = 0, mbox = 0;
  int q[$];
  int q1[$];
  always #5 clk = ~clk;
  majority_counter d0 (
    .clk(clk), .rst_n(rst_n), .store(store), .core_result(cr), .flush(flush),
    .sign_bit(sign0), .zero_flag(zero0), .acc_valid(acc0), .busy(busy0)
`ifdef MAJORITY_COUNTER_SAT_EN
    , .sat_flag(sat0)
`endif
  );
  majority_counter #(.W(6), .CORENUM(5), .GROUP(2)) d1 (
    .clk(clk), .rst_n(rst_n), .store(st1), .core_result(cr1), .flush(fl1),
    .sign_bit(sign1), .zero_flag(zero1), .acc_valid(acc1), .busy(busy1)
`ifdef MAJORITY_COUNTER_SAT_EN
    , .sat_flag(sat1)
`endif
  );
  function automatic int box0();
    return int'($signed(d0.box_q));
  endfunction
  function automatic int box1();
    return int'($signed(d1.box_q));
  endfunction
  function automatic int delta(logic [15:0] s, logic [15:0] c);
    int d = 0;
    for (int k = 0; k < 16; k++) if (s[k]) d += c[k] ? 1 : -1;
    return d;
  endfunction
  task automatic do_flush();
    flush = 1'b1; fl1 = 1'b1;
    @(negedge clk);
    flush = 1'b0; fl1 = 1'b0;
    mbox = 0; q.delete(); q1.delete();
  endtask
  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    nvec++; if (sign0 !== 1'b0) begin nerr++; $display("FAIL reset_sign got %b want 0", sign0); end
    nvec++; if (zero0 !== 1'b1) begin nerr++; $display("FAIL reset_zero got %b want 1", zero0); end
    nvec++; if (acc0 !== 1'b0) begin nerr++; $display("FAIL reset_acc got %b want 0", acc0); end
    nvec++; if (busy0 !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", busy0); end
    nvec++; if (box0() !== 0) begin nerr++; $display("FAIL reset_box got %0d want 0", box0()); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_single();
    int n, e;
    store = 16'hFFFF; cr = 16'hFFFF;
    mbox += delta(store, cr); q.push_back(mbox);
    @(negedge clk);
    store = '0;
    nvec++; if (busy0 !== 1'b1) begin nerr++; $display("FAIL single_busy got %b want 1", busy0); end
    n = 1;
    while (!acc0 && n < 8) begin @(negedge clk); n++; end
    nvec++; if (n !== 3) begin nerr++; $display("FAIL single_latency got %0d want 3", n); end
    e = q.pop_front();
    nvec++; if (box0() !== e) begin nerr++; $display("FAIL single_box got %0d want %0d", box0(), e); end
    nvec++; if (sign0 !== 1'b0) begin nerr++; $display("FAIL single_sign got %b want 0", sign0); end
    @(negedge clk);
    nvec++; if (acc0 !== 1'b0) begin nerr++; $display("FAIL single_pulse got %b want 0", acc0); end
    nvec++; if (busy0 !== 1'b0) begin nerr++; $display("FAIL single_idle got %b want 0", busy0); end
  endtask
  task automatic test_back_to_back();
    int e;
    do_flush();
    for (int i = 0; i < 3; i++) begin
      store = 16'h00FF; cr = 16'h0000;
      mbox += delta(store, cr); q.push_back(mbox);
      @(negedge clk);
    end
    store = '0;
    for (int i = 0; i < 3; i++) begin
      e = q.size() ? q.pop_front() : 0;
      nvec++; if (acc0 !== 1'b1) begin nerr++; $display("FAIL b2b_acc%0d got %b want 1", i, acc0); end
      nvec++; if (box0() !== e) begin nerr++; $display("FAIL b2b_box%0d got %0d want %0d", i, box0(), e); end
      nvec++; if (sign0 !== 1'b1) begin nerr++; $display("FAIL b2b_sign%0d got %b want 1", i, sign0); end
      @(negedge clk);
    end
    nvec++; if (acc0 !== 1'b0) begin nerr++; $display("FAIL b2b_end got %b want 0", acc0); end
  endtask
  task automatic test_tie();
    int n, e;
    do_flush();
    store = 16'h0003; cr = 16'h0001;
    mbox += delta(store, cr); q.push_back(mbox);
    @(negedge clk);
    store = '0;
    n = 1;
    while (!acc0 && n < 8) begin @(negedge clk); n++; end
    e = q.pop_front();
    nvec++; if (acc0 !== 1'b1) begin nerr++; $display("FAIL tie_acc got %b want 1", acc0); end
    nvec++; if (box0() !== e) begin nerr++; $display("FAIL tie_box got %0d want %0d", box0(), e); end
    nvec++; if (zero0 !== 1'b1) begin nerr++; $display("FAIL tie_zero got %b want 1", zero0); end
  endtask
  task automatic test_flush();
    int pulses;
    do_flush();
    for (int i = 0; i < 3; i++) begin
      store = (i == 2) ? 16'h00FF : 16'hFFFF; cr = store;
      mbox += delta(store, cr); q.push_back(mbox);
      @(negedge clk);
    end
    store = '0;
    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      if (acc0) begin
        nvec++; if (box0() !== q[0]) begin nerr++; $display("FAIL flush_build got %0d want %0d", box0(), q[0]); end
        void'(q.pop_front());
      end
      @(negedge clk);
    end
    nvec++; if (box0() !== 40) begin nerr++; $display("FAIL flush_pre got %0d want 40", box0()); end
    store = 16'hFFFF; cr = 16'h0000;
    @(negedge clk);
    store = 16'h00F0; cr = 16'h00F0;
    @(negedge clk);
    flush = 1'b1; store = 16'hFFFF; cr = 16'hFFFF;
    @(negedge clk);
    flush = 1'b0; store = '0; mbox = 0;
    nvec++; if (box0() !== 0) begin nerr++; $display("FAIL flush_box got %0d want 0", box0()); end
    nvec++; if (zero0 !== 1'b1) begin nerr++; $display("FAIL flush_zero got %b want 1", zero0); end
    nvec++; if (acc0 !== 1'b0) begin nerr++; $display("FAIL flush_acc got %b want 0", acc0); end
    nvec++; if (busy0 !== 1'b0) begin nerr++; $display("FAIL flush_busy got %b want 0", busy0); end
    pulses = 0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); if (acc0) pulses++; end
    nvec++; if (pulses !== 0) begin nerr++; $display("FAIL flush_stale got %0d pulses want 0", pulses); end
    nvec++; if (box0() !== 0) begin nerr++; $display("FAIL flush_hold got %0d want 0", box0()); end
  endtask
  task automatic test_random();
    do_flush();
    for (int i = 0; i < 30; i++) begin
      if (acc0) begin
        nvec++;
        if (q.size() == 0) begin nerr++; $display("FAIL rand_extra got box %0d want no pulse", box0()); end
        else begin
          if (box0() !== q[0]) begin nerr++; $display("FAIL rand_box got %0d want %0d", box0(), q[0]); end
          void'(q.pop_front());
        end
      end
      if (i < 24) begin
        store = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
        cr = 16'($urandom);
        if (store != 0) begin mbox += delta(store, cr); q.push_back(mbox); end
      end else store = '0;
      @(negedge clk);
    end
    nvec++; if (q.size() !== 0) begin nerr++; $display("FAIL rand_missing got %0d pending want 0", q.size()); end
  endtask
  task automatic test_async_reset();
    int n, e, pulses;
    do_flush();
    for (int i = 0; i < 4; i++) begin
      store = 16'hFFFF; cr = 16'h0000;
      mbox += delta(store, cr); q.push_back(mbox);
      @(negedge clk);
    end
    nvec++; if (box0() !== q[1]) begin nerr++; $display("FAIL areset_pre got %0d want %0d", box0(), q[1]); end
    nvec++; if (sign0 !== 1'b1) begin nerr++; $display("FAIL areset_presign got %b want 1", sign0); end
    #2 rst_n = 1'b0;
    #1;
    nvec++; if (sign0 !== 1'b0) begin nerr++; $display("FAIL areset_sign got %b want 0", sign0); end
    nvec++; if (zero0 !== 1'b1) begin nerr++; $display("FAIL areset_zero got %b want 1", zero0); end
    nvec++; if (acc0 !== 1'b0) begin nerr++; $display("FAIL areset_acc got %b want 0", acc0); end
    nvec++; if (busy0 !== 1'b0) begin nerr++; $display("FAIL areset_busy got %b want 0", busy0); end
    q.delete(); mbox = 0;
    @(negedge clk);
    rst_n = 1'b1; store = '0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (acc0) pulses++; end
    nvec++; if (pulses !== 0) begin nerr++; $display("FAIL areset_stale got %0d pulses want 0", pulses); end
    nvec++; if (box0() !== 0) begin nerr++; $display("FAIL areset_box got %0d want 0", box0()); end
    store = 16'hFFFF; cr = 16'hFFFF;
    mbox += delta(store, cr); q.push_back(mbox);
    @(negedge clk);
    store = '0;
    n = 1;
    while (!acc0 && n < 8) begin @(negedge clk); n++; end
    e = q.pop_front();
    nvec++; if (n !== 3) begin nerr++; $display("FAIL areset_first_lat got %0d want 3", n); end
    nvec++; if (box0() !== e) begin nerr++; $display("FAIL areset_first_box got %0d want %0d", box0(), e); end
  endtask
  task automatic test_sat_wrap();
    int mb, nb;
    do_flush();
    mb = 0;
`ifdef MAJORITY_COUNTER_SAT_EN
    nvec++; if (sat1 !== 1'b0) begin nerr++; $display("FAIL sat_pre got %b want 0", sat1); end
`endif
    for (int i = 0; i < 11; i++) begin
      if (acc1) begin
        nvec++;
        if (q1.size() == 0) begin nerr++; $display("FAIL sw_extra got box %0d want no pulse", box1()); end
        else begin
          if (box1() !== q1[0]) begin nerr++; $display("FAIL sw_box got %0d want %0d", box1(), q1[0]); end
          void'(q1.pop_front());
        end
      end
      if (i < 7) begin
        st1 = 5'h1F; cr1 = 5'h1F;
        nb = mb + 5;
`ifdef MAJORITY_COUNTER_SAT_EN
        if (nb > 31) nb = 31;
`else
        if (nb > 31) nb -= 64;
`endif
        mb = nb; q1.push_back(nb);
      end else st1 = '0;
      @(negedge clk);
    end
    nvec++; if (q1.size() !== 0) begin nerr++; $display("FAIL sw_missing got %0d pending want 0", q1.size()); end
`ifdef MAJORITY_COUNTER_SAT_EN
    nvec++; if (box1() !== 31) begin nerr++; $display("FAIL sat_box got %0d want 31", box1()); end
    nvec++; if (sign1 !== 1'b0) begin nerr++; $display("FAIL sat_sign got %b want 0", sign1); end
    nvec++; if (sat1 !== 1'b1) begin nerr++; $display("FAIL sat_flag got %b want 1", sat1); end
    do_flush();
    nvec++; if (sat1 !== 1'b0) begin nerr++; $display("FAIL sat_clear got %b want 0", sat1); end
`else
    nvec++; if (box1() !== -29) begin nerr++; $display("FAIL wrap_box got %0d want -29", box1()); end
    nvec++; if (sign1 !== 1'b1) begin nerr++; $display("FAIL wrap_sign got %b want 1", sign1); end
`endif
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_tie();
    test_flush();
    test_random();
    test_async_reset();
    test_sat_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end
endmodule

// File: doc/majority_counter.md
MAJORITY_COUNTER -- requirements
Module: majority_counter

Interface
REQ-001 SHALL have parameter W, default 30: accumulator width in bits, signed two's complement.
REQ-002 SHALL have parameter CORENUM, default 16: number of core lanes, legal range 1..64.
REQ-003 SHALL have parameter GROUP, default 4: lanes per first-level partial sum, legal range 1..CORENUM.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port store, input, CORENUM: per-lane vote-valid strobe.
REQ-007 SHALL have port core_result, input, CORENUM: per-lane vote bit; 1 = +1, 0 = -1.
REQ-008 SHALL have port flush, input, 1: synchronous clear of the accumulator and the pipeline.
REQ-009 SHALL have port sign_bit, output, 1: box[W-1], the majority result, where 1 = negative.
REQ-010 SHALL have port zero_flag, output, 1: high when box == 0 (tie).
REQ-011 SHALL have port acc_valid, output, 1: one-cycle pulse in the cycle after box is updated.
REQ-012 SHALL have port busy, output, 1: high while any pipeline stage holds a valid vote set.

Function
REQ-013 Stage S1 SHALL register sel[k] for each lane in the cycle store is sampled: +1 if store[k] && core_result[k]; -1 if store[k] && !core_result[k]; 0 otherwise.
REQ-014 S1 valid SHALL equal the OR of store across all lanes.
REQ-015 Stage S2 SHALL register NG = ceil(CORENUM/GROUP) signed partial sums; lanes past CORENUM in the last group contribute 0.
REQ-016 Each partial sum SHALL be clog2(GROUP+1)+1 bits wide, so no partial sum can overflow.
REQ-017 Stage S3 SHALL set box <= box + sum of all NG partials when S2 is valid; all operands are sign-extended to W bits.
REQ-018 Latency SHALL be 3 cycles: store sampled at edge t updates box at edge t+3, and acc_valid is high during cycle t+3.
REQ-019 The pipeline SHALL accept a store every cycle with no bubbles; back-to-back stores SHALL each be accumulated exactly once.
REQ-020 When store has no bits set, the pipeline SHALL insert no valid and SHALL leave box unchanged.
REQ-021 Sampling flush at edge t SHALL zero box and all stage valids at t+1.
REQ-022 A store sampled in the same cycle as flush SHALL be discarded.
REQ-023 An in-flight vote set SHALL NOT update box after a flush.
REQ-024 acc_valid SHALL be low in the cycle after a flush.
REQ-025 busy SHALL equal the OR of the S1, S2 and S3 valid bits.
REQ-026 sign_bit and zero_flag SHALL be derived combinationally from box, with no added latency.
REQ-027 Without saturation, box overflow SHALL wrap modulo 2^W.

Reset
REQ-028 While rst_n = 0, box, all partial sums, all sel values and all stage valids SHALL be 0, regardless of clk.
REQ-029 Reset value of the outputs SHALL be sign_bit = 0, zero_flag = 1, acc_valid = 0, busy = 0.
REQ-030 Reset asserted mid-accumulation SHALL discard all in-flight votes.
REQ-031 The first store sampled after rst_n deasserts SHALL be treated exactly as one sampled after a flush.

Configuration
REQ-032 When macro MAJORITY_COUNTER_SAT_EN is defined, box SHALL saturate at +(2^(W-1)-1) and at -(2^(W-1)) instead of wrapping.
REQ-033 When MAJORITY_COUNTER_SAT_EN is defined, a sticky output sat_flag SHALL be added; it is set on any clamp and cleared by flush or reset.
REQ-034 When MAJORITY_COUNTER_SAT_EN is undefined, sat_flag SHALL NOT exist and the wrap behaviour of REQ-027 SHALL apply.

Verification
REQ-035 Defaults; after reset, store = 0xFFFF with core_result = 0xFFFF for 1 cycle -> box = 16 at edge t+3, acc_valid pulses once, sign_bit = 0.
REQ-036 Defaults; core_result = 0x0000 with store = 0x00FF for 3 consecutive cycles -> box = -8, then -16, then -24 on consecutive edges; sign_bit = 1 from the first update.
REQ-037 Defaults; store = 0x0003, core_result = 0x0001 -> box stays 0, zero_flag = 1, acc_valid pulses.
REQ-038 Defaults; box = 40, 2 votes in flight, flush asserted -> box = 0 next edge, no later acc_valid, busy = 0 after 1 cycle.
REQ-039 W = 6, CORENUM = 5, GROUP = 2; +5 per cycle for 7 cycles -> with MAJORITY_COUNTER_SAT_EN: box = 31, sat_flag = 1; without it: box wraps to -29.
REQ-040 rst_n pulsed low asynchronously between edges during a store burst -> all outputs reach reset values immediately; no stale update occurs after release.
